// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32IM control stage: opcodes, ALU operation
// codes, load/store/branch sub-codes, the registered control bundle and the
// stage state enum.
package rv_ctrl_pkg;

  // Major opcodes (instruction bits [6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // funct7 classes for R-type and shift-immediate forms
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // ALU operation codes
  localparam logic [4:0] ALU_ADD    = 5'b00001;
  localparam logic [4:0] ALU_AND    = 5'b00010;
  localparam logic [4:0] ALU_OR     = 5'b00011;
  localparam logic [4:0] ALU_XOR    = 5'b00100;
  localparam logic [4:0] ALU_SLL    = 5'b00101;
  localparam logic [4:0] ALU_SRL    = 5'b00110;
  localparam logic [4:0] ALU_SRA    = 5'b00111;
  localparam logic [4:0] ALU_SUB    = 5'b01000;
  localparam logic [4:0] ALU_MUL    = 5'b01001;
  localparam logic [4:0] ALU_MULH   = 5'b01010;
  localparam logic [4:0] ALU_MULHU  = 5'b01011;
  localparam logic [4:0] ALU_MULHSU = 5'b01100;
  localparam logic [4:0] ALU_DIV    = 5'b01101;
  localparam logic [4:0] ALU_DIVU   = 5'b01110;
  localparam logic [4:0] ALU_REM    = 5'b01111;
  localparam logic [4:0] ALU_REMU   = 5'b10000;
  localparam logic [4:0] ALU_SLT    = 5'b10001;
  localparam logic [4:0] ALU_SLTU   = 5'b10010;

  // LOADSIGNAL codes; LD_UPPER marks LUI/AUIPC
  localparam logic [2:0] LD_NONE  = 3'd0;
  localparam logic [2:0] LD_LB    = 3'd1;
  localparam logic [2:0] LD_LH    = 3'd2;
  localparam logic [2:0] LD_LW    = 3'd3;
  localparam logic [2:0] LD_LBU   = 3'd4;
  localparam logic [2:0] LD_LHU   = 3'd5;
  localparam logic [2:0] LD_UPPER = 3'd6;

  // STORESIGNAL codes
  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_SB   = 2'd1;
  localparam logic [1:0] ST_SH   = 2'd2;
  localparam logic [1:0] ST_SW   = 2'd3;

  // BRANCHSIGNAL codes
  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_BLTU = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;

  // Stage occupancy: RUN single-cycle, MEM waiting on data memory, MDU
  // counting down a multi-cycle multiply/divide.
  typedef enum logic [1:0] {
    RUN = 2'd0,
    MEM = 2'd1,
    MDU = 2'd2
  } state_t;

  // Control bundle held in the decode->execute register. WRITEENABLE is
  // stored as "this instruction writes back"; the stage gates it in time.
  typedef struct packed {
    logic [4:0] aluop;
    logic       imm;
    logic       selwrite;
    logic       jump;
    logic       read;
    logic       write;
    logic       we;
    logic [2:0] load;
    logic [1:0] store;
    logic [2:0] branch;
  } ctrl_t;

  // ALU op shared by OP and OP-IMM; alt selects SUB/SRA.
  function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
    logic [4:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // ALU op for the M extension (funct7 = 0000001).
  function automatic logic [4:0] alu_mdu(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      3'b000:  op = ALU_MUL;
      3'b001:  op = ALU_MULH;
      3'b010:  op = ALU_MULHSU;
      3'b011:  op = ALU_MULHU;
      3'b100:  op = ALU_DIV;
      3'b101:  op = ALU_DIVU;
      3'b110:  op = ALU_REM;
      default: op = ALU_REMU;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_ctrl_if.sv
// Bundle between IF/ID, data memory and the control stage.
//
// Handshake: an instruction transfers on a rising edge when INSTR_VALID=1,
// STALL=0 and FLUSH=0. While STALL=1 the producer must hold INSTRUCTION
// steady; it is not consumed. BUSYWAIT=1 from data memory means the current
// load/store has not completed, and READ/WRITE stay asserted until it drops.
interface rv_ctrl_if;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;
  logic        FLUSH;
  logic        BUSYWAIT;

  logic [4:0]  ALUOP;
  logic        IMMflag;
  logic        SELECTWRITE;
  logic        Jumpflag;
  logic        READ;
  logic        WRITE;
  logic        WRITEENABLE;
  logic [2:0]  LOADSIGNAL;
  logic [1:0]  STORESIGNAL;
  logic [2:0]  BRANCHSIGNAL;
  logic        CTRL_VALID;
  logic        ILLEGAL;
  logic        STALL;

  modport master (
    output INSTRUCTION, INSTR_VALID, FLUSH, BUSYWAIT,
    input  ALUOP, IMMflag, SELECTWRITE, Jumpflag, READ, WRITE, WRITEENABLE,
           LOADSIGNAL, STORESIGNAL, BRANCHSIGNAL, CTRL_VALID, ILLEGAL, STALL
  );

  modport slave (
    input  INSTRUCTION, INSTR_VALID, FLUSH, BUSYWAIT,
    output ALUOP, IMMflag, SELECTWRITE, Jumpflag, READ, WRITE, WRITEENABLE,
           LOADSIGNAL, STORESIGNAL, BRANCHSIGNAL, CTRL_VALID, ILLEGAL, STALL
  );
endinterface

// File: rtl/rv_ctrl_decode.sv
// Combinational RV32IM decoder: instruction word to control bundle, plus
// classification flags used by the stage FSM. Anything undecodable yields an
// all-zero bundle with illegal=1.
module rv_ctrl_decode
  import rv_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        is_mem,
  output logic        is_mdu_mul,
  output logic        is_mdu_div,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       bad;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Register specifiers are not needed for control decode.
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  // Decode opcode/funct3/funct7 into the bundle; squash to zero if illegal.
  always_comb begin
    ctrl       = '0;
    is_mem     = 1'b0;
    is_mdu_mul = 1'b0;
    is_mdu_div = 1'b0;
    bad        = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        ctrl.aluop = ALU_ADD;
        ctrl.imm   = 1'b1;
        ctrl.load  = LD_UPPER;
        ctrl.we    = 1'b1;
      end
      OPC_JAL: begin
        ctrl.aluop = ALU_ADD;
        ctrl.imm   = 1'b1;
        ctrl.jump  = 1'b1;
        ctrl.we    = 1'b1;
      end
      OPC_JALR: begin
        ctrl.aluop = ALU_ADD;
        ctrl.imm   = 1'b1;
        ctrl.jump  = 1'b1;
        ctrl.we    = 1'b1;
        bad        = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        ctrl.aluop = ALU_SUB;
        case (funct3)
          3'b000:  ctrl.branch = BR_BEQ;
          3'b001:  ctrl.branch = BR_BNE;
          3'b100:  ctrl.branch = BR_BLT;
          3'b101:  ctrl.branch = BR_BGE;
          3'b110:  ctrl.branch = BR_BLTU;
          3'b111:  ctrl.branch = BR_BGEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        ctrl.aluop    = ALU_ADD;
        ctrl.imm      = 1'b1;
        ctrl.read     = 1'b1;
        ctrl.selwrite = 1'b1;
        ctrl.we       = 1'b1;
        is_mem        = 1'b1;
        case (funct3)
          3'b000:  ctrl.load = LD_LB;
          3'b001:  ctrl.load = LD_LH;
          3'b010:  ctrl.load = LD_LW;
          3'b100:  ctrl.load = LD_LBU;
          3'b101:  ctrl.load = LD_LHU;
          default: bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        ctrl.aluop = ALU_ADD;
        ctrl.imm   = 1'b1;
        ctrl.write = 1'b1;
        is_mem     = 1'b1;
        case (funct3)
          3'b000:  ctrl.store = ST_SB;
          3'b001:  ctrl.store = ST_SH;
          3'b010:  ctrl.store = ST_SW;
          default: bad = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        ctrl.imm   = 1'b1;
        ctrl.we    = 1'b1;
        ctrl.aluop = alu_base(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
        if (funct3 == 3'b001) begin
          bad = (funct7 != F7_BASE);
        end else if (funct3 == 3'b101) begin
          bad = (funct7 != F7_BASE) && (funct7 != F7_ALT);
        end
      end
      OPC_OP: begin
        ctrl.we = 1'b1;
        case (funct7)
          F7_BASE: ctrl.aluop = alu_base(funct3, 1'b0);
          F7_ALT: begin
            if ((funct3 == 3'b000) || (funct3 == 3'b101)) begin
              ctrl.aluop = alu_base(funct3, 1'b1);
            end else begin
              bad = 1'b1;
            end
          end
          F7_MULDIV: begin
            if (ENABLE_M) begin
              ctrl.aluop = alu_mdu(funct3);
              is_mdu_mul = ~funct3[2];
              is_mdu_div = funct3[2];
            end else begin
              bad = 1'b1;
            end
          end
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      ctrl       = '0;
      is_mem     = 1'b0;
      is_mdu_mul = 1'b0;
      is_mdu_div = 1'b0;
    end
  end

  assign illegal = bad;

endmodule

// File: rtl/rv_ctrl_stage.sv
// Decode->execute control register with stall handling: memory ops wait on
// BUSYWAIT, multiply/divide ops occupy execute for a fixed cycle count, and
// FLUSH turns the instruction being captured into a bubble.
module rv_ctrl_stage
  import rv_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 33,
  parameter bit ENABLE_M   = 1'b1
) (
  input  logic   CLK,
  input  logic   RESET,
  rv_ctrl_if.slave bus,
  output state_t dbg_state
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  // Counter holds N-1 at most.
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef logic [CNT_W-1:0] cnt_t;

  ctrl_t  dec_ctrl;
  logic   dec_is_mem, dec_is_mul, dec_is_div, dec_illegal;

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   valid_q, valid_d;
  logic   ill_q, ill_d;
  cnt_t   cnt_q, cnt_d;
  logic   stall, we_gate, take;

  rv_ctrl_decode #(.ENABLE_M(ENABLE_M)) u_decode (
    .instr      (bus.INSTRUCTION),
    .ctrl       (dec_ctrl),
    .is_mem     (dec_is_mem),
    .is_mdu_mul (dec_is_mul),
    .is_mdu_div (dec_is_div),
    .illegal    (dec_illegal)
  );

  // State, control register and latency counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= RUN;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stall/write-enable timing per state, and capture of the next instruction
  // whenever the current one is in its final cycle.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    we_gate = 1'b1;
    take    = 1'b0;
    case (state_q)
      MEM: begin
        stall   = bus.BUSYWAIT;
        we_gate = ~bus.BUSYWAIT;
      end
      MDU: begin
        stall   = (cnt_q != '0);
        we_gate = (cnt_q == '0);
      end
      default: ;
    endcase
    if (stall) begin
      // The held op is older than any branch, so FLUSH has no effect here.
      if (state_q == MDU) begin
        cnt_d = cnt_q - cnt_t'(1);
      end
    end else begin
      take    = bus.INSTR_VALID & ~bus.FLUSH;
      ctrl_d  = take ? dec_ctrl : '0;
      valid_d = take;
      ill_d   = take & dec_illegal;
      cnt_d   = '0;
      state_d = RUN;
      if (take & dec_is_mem) begin
        state_d = MEM;
      end else if (take & dec_is_mul & (MUL_CYCLES > 1)) begin
        state_d = MDU;
        cnt_d   = cnt_t'(MUL_CYCLES - 1);
      end else if (take & dec_is_div & (DIV_CYCLES > 1)) begin
        state_d = MDU;
        cnt_d   = cnt_t'(DIV_CYCLES - 1);
      end
    end
  end

  assign bus.ALUOP        = ctrl_q.aluop;
  assign bus.IMMflag      = ctrl_q.imm;
  assign bus.SELECTWRITE  = ctrl_q.selwrite;
  assign bus.Jumpflag     = ctrl_q.jump;
  assign bus.READ         = ctrl_q.read;
  assign bus.WRITE        = ctrl_q.write;
  assign bus.WRITEENABLE  = ctrl_q.we & we_gate;
  assign bus.LOADSIGNAL   = ctrl_q.load;
  assign bus.STORESIGNAL  = ctrl_q.store;
  assign bus.BRANCHSIGNAL = ctrl_q.branch;
  assign bus.CTRL_VALID   = valid_q;
  assign bus.ILLEGAL      = ill_q;
  assign bus.STALL        = stall;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_rv_ctrl_stage.sv
// Directed bench for rv_ctrl_stage. Each cycle the bench drives inputs on the
// falling edge, pushes the rows the driven instruction should produce, and
// compares the settled outputs of the current cycle with the queue head.
module tb_rv_ctrl_stage;
  import rv_ctrl_pkg::*;

  localparam int W = 22;

  localparam logic [31:0] I_ADDI  = 32'h00500093;
  localparam logic [31:0] I_LW    = 32'h00012283;
  localparam logic [31:0] I_DIV   = 32'h02C5C533;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_BEQ   = 32'h00000063;
  localparam logic [31:0] I_MUL   = 32'h02C58533;
  localparam logic [31:0] I_ILL   = 32'h0000007F;
  localparam logic [31:0] I_SW    = 32'h00512023;
  localparam logic [31:0] I_LUI   = 32'h123450B7;
  localparam logic [31:0] I_JAL   = 32'h000000EF;
  localparam logic [31:0] I_SRAI  = 32'h4030D093;
  localparam logic [31:0] I_BADBR = 32'h00002063;
  localparam logic [31:0] I_LBU   = 32'h00014083;

  // clock / reset
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  rv_ctrl_if bus ();
  rv_ctrl_if bus_n ();
  state_t dbg_state, dbg_state_n;

  rv_ctrl_stage #(.MUL_CYCLES(1), .DIV_CYCLES(33), .ENABLE_M(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus), .dbg_state(dbg_state)
  );

  // Same stimulus, M extension disabled.
  rv_ctrl_stage #(.MUL_CYCLES(1), .DIV_CYCLES(33), .ENABLE_M(1'b0)) dut_nom (
    .CLK(CLK), .RESET(RESET), .bus(bus_n), .dbg_state(dbg_state_n)
  );

  assign bus_n.INSTRUCTION = bus.INSTRUCTION;
  assign bus_n.INSTR_VALID = bus.INSTR_VALID;
  assign bus_n.FLUSH       = bus.FLUSH;
  assign bus_n.BUSYWAIT    = bus.BUSYWAIT;

  // Observed row: {valid, illegal, stall, we, read, write, selwrite, jump,
  // imm, aluop, load, store, branch}
  logic [W-1:0] obs_a, obs_n;
  assign obs_a = {bus.CTRL_VALID, bus.ILLEGAL, bus.STALL, bus.WRITEENABLE, bus.READ,
                  bus.WRITE, bus.SELECTWRITE, bus.Jumpflag, bus.IMMflag, bus.ALUOP,
                  bus.LOADSIGNAL, bus.STORESIGNAL, bus.BRANCHSIGNAL};
  assign obs_n = {bus_n.CTRL_VALID, bus_n.ILLEGAL, bus_n.STALL, bus_n.WRITEENABLE, bus_n.READ,
                  bus_n.WRITE, bus_n.SELECTWRITE, bus_n.Jumpflag, bus_n.IMMflag, bus_n.ALUOP,
                  bus_n.LOADSIGNAL, bus_n.STORESIGNAL, bus_n.BRANCHSIGNAL};

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [W-1:0] mk(input logic v, input logic il, input logic st,
                                      input logic we, input logic rd, input logic wr,
                                      input logic sw, input logic jf, input logic im,
                                      input logic [4:0] alu, input logic [2:0] ld,
                                      input logic [1:0] sd, input logic [2:0] br);
    return {v, il, st, we, rd, wr, sw, jf, im, alu, ld, sd, br};
  endfunction

  localparam logic [W-1:0] BUBBLE = '0;

  function automatic logic [W-1:0] r_addi();
    return mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 5'b00001, 3'd0, 2'd0, 3'd0);
  endfunction
  function automatic logic [W-1:0] r_lw(input logic bw);
    return mk(1, 0, bw, ~bw, 1, 0, 1, 0, 1, 5'b00001, 3'd3, 2'd0, 3'd0);
  endfunction
  function automatic logic [W-1:0] r_div(input int i);
    return mk(1, 0, (i < 33), (i == 33), 0, 0, 0, 0, 0, 5'b01101, 3'd0, 2'd0, 3'd0);
  endfunction
  function automatic logic [W-1:0] r_sw(input logic bw);
    return mk(1, 0, bw, 0, 0, 1, 0, 0, 1, 5'b00001, 3'd0, 2'd3, 3'd0);
  endfunction
  function automatic logic [W-1:0] r_ill();
    return mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 3'd0, 2'd0, 3'd0);
  endfunction

  // driver: present inputs for one cycle, check this cycle's outputs
  task automatic cyc(input logic [31:0] ins, input logic v, input logic fl,
                     input logic bw, input string tag);
    logic [W-1:0] exp;
    bus.INSTRUCTION = ins;
    bus.INSTR_VALID = v;
    bus.FLUSH       = fl;
    bus.BUSYWAIT    = bw;
    #1;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs_a);
    end else begin
      exp = exp_q.pop_front();
      assert (obs_a === exp) else begin
        n_errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs_a, exp);
      end
    end
    @(negedge CLK);
  endtask

  task automatic check_state(input state_t got, input state_t want, input string tag);
    n_checks++;
    assert (got === want) else begin
      n_errors++;
      $error("FAIL %s: observed %s expected %s", tag, got.name(), want.name());
    end
  endtask

  initial begin
    RESET = 1'b1;
    bus.INSTRUCTION = '0;
    bus.INSTR_VALID = 1'b0;
    bus.FLUSH       = 1'b0;
    bus.BUSYWAIT    = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    check_state(dbg_state, RUN, "reset_state_fsm");
    exp_q.push_back(BUBBLE);

    // ADDI then LW with three busy cycles
    exp_q.push_back(r_addi());
    cyc(I_ADDI, 1, 0, 0, "reset_outputs");
    for (int i = 0; i < 3; i++) exp_q.push_back(r_lw(1'b1));
    exp_q.push_back(r_lw(1'b0));
    cyc(I_LW, 1, 0, 0, "addi");
    check_state(dbg_state, MEM, "lw_state");
    cyc(I_SUB, 1, 0, 1, "lw_busy1");
    cyc(I_SUB, 1, 1, 1, "lw_busy2_flush_ignored");
    cyc(I_SUB, 1, 0, 1, "lw_busy3");
    exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 5'b01000, 3'd0, 2'd0, 3'd0));
    cyc(I_SUB, 1, 0, 0, "lw_complete");

    // DIV: 33 cycles, flushes and BUSYWAIT noise ignored while stalled
    for (int i = 1; i <= 33; i++) exp_q.push_back(r_div(i));
    cyc(I_DIV, 1, 0, 0, "sub");
    check_state(dbg_state, MDU, "div_state");
    n_checks++;
    assert (obs_n === r_ill()) else begin
      n_errors++;
      $error("FAIL div_no_m_ext: observed %h expected %h", obs_n, r_ill());
    end
    check_state(dbg_state_n, RUN, "div_no_m_ext_state");
    for (int i = 1; i <= 32; i++)
      cyc(I_ADDI, 1, 1'(i % 2), 1'($urandom_range(0, 1)), "div_stall");
    exp_q.push_back(r_addi());
    cyc(I_ADDI, 1, 0, 0, "div_final");

    // BEQ, then the slot presented with FLUSH becomes a bubble
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01000, 3'd0, 2'd0, 3'd1));
    cyc(I_BEQ, 1, 0, 0, "addi_after_div");
    exp_q.push_back(BUBBLE);
    cyc(I_ADDI, 1, 1, 0, "beq");
    exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 5'b01001, 3'd0, 2'd0, 3'd0));
    cyc(I_MUL, 1, 0, 0, "flush_bubble");
    exp_q.push_back(r_ill());
    cyc(I_ILL, 1, 0, 0, "mul_single_cycle");

    // store with one busy cycle, then assorted decodes
    exp_q.push_back(r_sw(1'b1));
    exp_q.push_back(r_sw(1'b0));
    cyc(I_SW, 1, 0, 0, "illegal_opcode_7f");
    cyc(I_ADDI, 1, 0, 1, "sw_busy");
    exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 5'b00001, 3'd6, 2'd0, 3'd0));
    cyc(I_LUI, 1, 0, 0, "sw_complete");
    exp_q.push_back(r_lw(1'b0));
    cyc(I_LW, 1, 0, 0, "lui");
    exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, 1, 5'b00001, 3'd0, 2'd0, 3'd0));
    cyc(I_JAL, 1, 0, 0, "lw_no_wait");
    exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 5'b00111, 3'd0, 2'd0, 3'd0));
    cyc(I_SRAI, 1, 0, 0, "jal");
    exp_q.push_back(r_ill());
    cyc(I_BADBR, 1, 0, 0, "srai");
    exp_q.push_back(mk(1, 0, 0, 1, 1, 0, 1, 0, 1, 5'b00001, 3'd4, 2'd0, 3'd0));
    cyc(I_LBU, 1, 0, 0, "illegal_branch_funct3");
    exp_q.push_back(BUBBLE);
    cyc(I_ADDI, 0, 0, 0, "lbu");

    // second DIV aborted by reset during its tenth cycle
    for (int i = 1; i <= 10; i++) exp_q.push_back(r_div(i));
    cyc(I_DIV, 1, 0, 0, "invalid_is_bubble");
    for (int i = 0; i < 9; i++) cyc(I_ADDI, 1, 0, 0, "div2_stall");
    RESET = 1'b1;
    exp_q.push_back(BUBBLE);
    cyc(I_ADDI, 1, 0, 0, "div2_cycle10");
    RESET = 1'b0;
    check_state(dbg_state, RUN, "reset_mid_div_state");
    exp_q.push_back(BUBBLE);
    cyc(32'h0, 0, 0, 0, "reset_mid_div_outputs");
    cyc(32'h0, 0, 0, 0, "idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
